// File: rtl/regwr_arbiter_pkg.sv
// Common constants and helpers for the register writeback arbiter.
`include "defs.vh"
package regwr_arbiter_pkg;
  localparam int REG_AW  = `REG_ADDR_WIDTH;
  localparam int MAX_REQ = `REGWR_MAX_REQ;
  localparam int IDX_W   = 2;

  // Index after p, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] p, input int n);
    return (int'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/defs.vh
// Shared widths for the register-bank writeback path.
`ifndef REGWR_DEFS_VH
`define REGWR_DEFS_VH
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`define REG_ADDR_WIDTH 5
`define REGWR_MAX_REQ 4
`endif

// File: rtl/regwr_rr_pick.sv
// Combinational rotate-priority picker: first valid at or after start wins.
module regwr_rr_pick
  import regwr_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(start) + k) % N);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/regwr_arbiter.sv
// Write-port arbiter for the 32-entry register bank; one registered write per cycle.
// Build option: define REGWR_RR_EN for round-robin, otherwise fixed lowest-index priority.
`include "defs.vh"
module regwr_arbiter
  import regwr_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_AW*NREQ-1:0]     req_dest,
  input  logic [DATA_WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       wr_en,
  output logic [REG_AW-1:0]          wr_dest,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [IDX_W-1:0]           grant_idx
);
  logic [NREQ-1:0][REG_AW-1:0]     dest_v;
  logic [NREQ-1:0][DATA_WIDTH-1:0] data_v;
  logic [NREQ-1:0]                 pick_grant;
  logic [IDX_W-1:0]                pick_idx;
  logic [IDX_W-1:0]                start;
  logic                            pick_any;
  logic                            accept;

  assign dest_v = req_dest;
  assign data_v = req_data;

`ifdef REGWR_RR_EN
  logic [IDX_W-1:0] ptr;

  assign start = rr_next(ptr, NREQ);

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk_in) begin
    if (rst_in)      ptr <= IDX_W'(NREQ - 1);
    else if (accept) ptr <= pick_idx;
  end
`else
  assign start = '0;
`endif

  regwr_rr_pick #(.N(NREQ)) u_pick (
    .valid (req_valid),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = rst_in ? '0 : pick_grant;
  assign accept    = pick_any & ~rst_in;

  // x0 writes are consumed but never reach the bank.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_en     <= 1'b0;
      wr_dest   <= '0;
      wr_data   <= '0;
      grant_idx <= '0;
    end else begin
      wr_en <= accept && (dest_v[pick_idx] != '0);
      if (accept) begin
        wr_dest   <= dest_v[pick_idx];
        wr_data   <= data_v[pick_idx];
        grant_idx <= pick_idx;
      end
    end
  end
endmodule
